// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-port sequencer: state encoding and the
// opcodes that need a RAM data phase or stop the machine.
package mem_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [3:0] OP_STR  = 4'b1001;
    localparam logic [3:0] OP_LDR  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_addr_mux.sv
// RAM address select: program counter during instruction fetch, latched
// data address during the memory phase, zero otherwise.
module mem_addr_mux
    import mem_seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int ADDR_W = 16
) (
    input  state_e            state_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [ADDR_W-1:0] addr_q_i,
    output logic [ADDR_W-1:0] ram_addr_o
);

    always_comb begin
        ram_addr_o = '0;
        case (state_i)
            S_FETCH: ram_addr_o = {{(ADDR_W-PC_W){1'b0}}, pc_i};
            S_MEM:   ram_addr_o = addr_q_i;
            default: ram_addr_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back controller sharing one
// RAM port between instruction fetch and LDR/STR data accesses.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] src2,
    output logic              ram_req,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic              exec_en,
    output logic [DATA_W-1:0] ldr_data,
    output logic              ldr_valid,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    // RAM handshake: a transfer completes on the rising edge where ram_req and
    // ram_ready are both high; address, flag and write data hold until then.

    state_e              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   instr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   ldr_data_q;
    logic [3:0]          opcode_w;

    assign opcode_w = instr_q[DATA_W-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ldr_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (ram_ready) begin
                        instr_q <= ram_rdata;
                        pc_q    <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= (opcode_w == OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (is_mem_op(opcode_w)) begin
                        addr_q  <= alu_result[ADDR_W-1:0];
                        wdata_q <= src2;
                        state_q <= S_MEM;
                    end else begin
                        state_q <= start ? S_FETCH : S_IDLE;
                    end
                end
                S_MEM: begin
                    if (ram_ready) begin
                        if (opcode_w == OP_LDR) begin
                            ldr_data_q <= ram_rdata;
                            state_q    <= S_WB;
                        end else begin
                            state_q <= start ? S_FETCH : S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    state_q <= start ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode keeps ram_req tied to the async-reset state register.
    assign ram_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ram_rw    = (state_q == S_MEM) && (opcode_w == OP_STR);
    assign exec_en   = (state_q == S_EXEC);
    assign ldr_valid = (state_q == S_WB);
    assign halted    = (state_q == S_HALT);
    assign ram_wdata = wdata_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = opcode_w;
    assign ldr_data  = ldr_data_q;
    assign dbg_state = state_q;

    mem_addr_mux #(
        .PC_W   (PC_W),
        .ADDR_W (ADDR_W)
    ) u_addr_mux (
        .state_i    (state_q),
        .pc_i       (pc_q),
        .addr_q_i   (addr_q),
        .ram_addr_o (ram_addr)
    );

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a small RAM model and a
// scoreboard of expected RAM transfers and load write-backs.
module tb_mem_port_sequencer;
    import mem_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ram_ready;
    logic [31:0] ram_rdata;
    logic [31:0] alu_result;
    logic [31:0] src2;
    logic        ram_req;
    logic        ram_rw;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic        exec_en;
    logic [31:0] ldr_data;
    logic        ldr_valid;
    logic        halted;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:255];
    logic [48:0] exp_q [$];
    logic [31:0] ldr_q [$];
    int checks   = 0;
    int errors   = 0;
    int exec_cnt = 0;

    mem_port_sequencer #(.PC_W(8), .ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_ready  (ram_ready),
        .ram_rdata  (ram_rdata),
        .alu_result (alu_result),
        .src2       (src2),
        .ram_req    (ram_req),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .pc         (pc),
        .instr      (instr),
        .opcode     (opcode),
        .exec_en    (exec_en),
        .ldr_data   (ldr_data),
        .ldr_valid  (ldr_valid),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_acc(input logic rw, input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back({rw, a, rw ? d : 32'h0});
    endtask

    // Monitors the current cycle (inputs already set) then advances one clock.
    task automatic step();
        logic [48:0] obs_acc;
        if (exec_en) exec_cnt++;
        if (ram_req && ram_ready) begin
            obs_acc = {ram_rw, ram_addr, ram_rw ? ram_wdata : 32'h0};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL acc_unexpected observed=%0h expected=none", obs_acc);
            end else begin
                chk("ram_access", {15'h0, obs_acc}, {15'h0, exp_q.pop_front()});
            end
            if (ram_rw) mem[ram_addr[7:0]] = ram_wdata;
        end
        if (ldr_valid) begin
            if (ldr_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL ldr_unexpected observed=%0h expected=none", ldr_data);
            end else begin
                chk("ldr_data", {32'h0, ldr_data}, {32'h0, ldr_q.pop_front()});
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  {61'h0, dbg_state}, {61'h0, ST_IDLE});
        chk({tag, "_req"},    {63'h0, ram_req}, 64'h0);
        chk({tag, "_rw"},     {63'h0, ram_rw}, 64'h0);
        chk({tag, "_addr"},   {48'h0, ram_addr}, 64'h0);
        chk({tag, "_wdata"},  {32'h0, ram_wdata}, 64'h0);
        chk({tag, "_pc"},     {56'h0, pc}, 64'h0);
        chk({tag, "_instr"},  {32'h0, instr}, 64'h0);
        chk({tag, "_opcode"}, {60'h0, opcode}, 64'h0);
        chk({tag, "_exec"},   {63'h0, exec_en}, 64'h0);
        chk({tag, "_ldata"},  {32'h0, ldr_data}, 64'h0);
        chk({tag, "_lvalid"}, {63'h0, ldr_valid}, 64'h0);
        chk({tag, "_halted"}, {63'h0, halted}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        ram_ready = 1'b1;
        alu_result = 32'h0;
        src2 = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exec_cnt = 0;
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        start = 1'b0;
        ram_ready = 1'b1;
        alu_result = 32'h0;
        src2 = 32'h0;

        // ALU op followed by HALT
        do_reset();
        chk_reset_vals("rst");
        mem[0] = 32'h4000_0000;
        mem[1] = 32'hF000_0000;
        push_acc(1'b0, 16'h0000, 32'h0);
        push_acc(1'b0, 16'h0001, 32'h0);
        start = 1'b1;
        step();
        chk("alu_fetch_state", {61'h0, dbg_state}, {61'h0, ST_FETCH});
        chk("alu_fetch_addr", {48'h0, ram_addr}, 64'h0);
        step();
        chk("alu_instr", {32'h0, instr}, 64'h4000_0000);
        chk("alu_pc", {56'h0, pc}, 64'h1);
        step();
        chk("alu_exec", {63'h0, exec_en}, 64'h1);
        step();
        chk("alu_refetch_state", {61'h0, dbg_state}, {61'h0, ST_FETCH});
        chk("alu_refetch_addr", {48'h0, ram_addr}, 64'h1);
        step();
        step();
        chk("halt_state", {61'h0, dbg_state}, {61'h0, ST_HALT});
        chk("halt_flag", {63'h0, halted}, 64'h1);
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            step();
        end
        chk("halt_sticky", {63'h0, halted}, 64'h1);
        chk("halt_req", {63'h0, ram_req}, 64'h0);
        chk("halt_exec_cnt", 64'(exec_cnt), 64'h1);

        // LDR
        do_reset();
        mem[0] = 32'hA000_0000;
        mem[1] = 32'hF000_0000;
        mem[2] = 32'h1234_5678;
        alu_result = 32'h0000_0002;
        push_acc(1'b0, 16'h0000, 32'h0);
        push_acc(1'b0, 16'h0002, 32'h0);
        push_acc(1'b0, 16'h0001, 32'h0);
        ldr_q.push_back(32'h1234_5678);
        start = 1'b1;
        step();
        step();
        step();
        step();
        chk("ldr_mem_state", {61'h0, dbg_state}, {61'h0, ST_MEM});
        chk("ldr_mem_addr", {48'h0, ram_addr}, 64'h2);
        chk("ldr_mem_rw", {63'h0, ram_rw}, 64'h0);
        step();
        chk("ldr_valid", {63'h0, ldr_valid}, 64'h1);
        chk("ldr_wb_data", {32'h0, ldr_data}, 64'h1234_5678);
        step();
        chk("ldr_next_fetch", {61'h0, dbg_state}, {61'h0, ST_FETCH});
        chk("ldr_next_addr", {48'h0, ram_addr}, 64'h1);
        step();
        step();
        chk("ldr_q_empty", 64'(ldr_q.size()), 64'h0);

        // STR with a two-cycle RAM stall
        do_reset();
        mem[0] = 32'h9000_0000;
        mem[1] = 32'hF000_0000;
        src2 = 32'h0000_0009;
        alu_result = 32'h0000_0003;
        push_acc(1'b0, 16'h0000, 32'h0);
        push_acc(1'b1, 16'h0003, 32'h9);
        push_acc(1'b0, 16'h0001, 32'h0);
        start = 1'b1;
        step();
        step();
        step();
        ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("str_state", {61'h0, dbg_state}, {61'h0, ST_MEM});
            chk("str_addr", {48'h0, ram_addr}, 64'h3);
            chk("str_rw", {63'h0, ram_rw}, 64'h1);
            chk("str_wdata", {32'h0, ram_wdata}, 64'h9);
            alu_result = 32'h0000_0077 + 32'(i);
            src2 = 32'h0000_0055;
            if (i == 2) ram_ready = 1'b1;
        end
        step();
        chk("str_next_addr", {48'h0, ram_addr}, 64'h1);
        chk("str_mem_written", {32'h0, mem[3]}, 64'h9);
        step();
        step();

        // pc wrap at 8'hFF
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h4000_0000;
            push_acc(1'b0, 16'(i), 32'h0);
        end
        push_acc(1'b0, 16'h0000, 32'h0);
        start = 1'b1;
        step();
        budget = 0;
        while (exp_q.size() > 1 && budget < 2000) begin
            step();
            budget++;
        end
        chk("wrap_budget", {63'h0, budget < 2000}, 64'h1);
        chk("wrap_pc", {56'h0, pc}, 64'h0);
        budget = 0;
        while (dbg_state != ST_FETCH && budget < 10) begin
            step();
            budget++;
        end
        chk("wrap_fetch_state", {61'h0, dbg_state}, {61'h0, ST_FETCH});
        chk("wrap_fetch_addr", {48'h0, ram_addr}, 64'h0);
        step();
        chk("wrap_q_empty", 64'(exp_q.size()), 64'h0);

        // Reset during a stalled LDR memory phase
        do_reset();
        mem[0] = 32'hA000_0000;
        alu_result = 32'h0000_0002;
        push_acc(1'b0, 16'h0000, 32'h0);
        start = 1'b1;
        step();
        step();
        step();
        ram_ready = 1'b0;
        step();
        chk("rmem_req", {63'h0, ram_req}, 64'h1);
        #1;
        rst = 1'b1;
        ram_ready = 1'b1;
        #1;
        chk_reset_vals("rmem");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rmem_idle", {61'h0, dbg_state}, {61'h0, ST_IDLE});
        chk("rmem_idle_pc", {56'h0, pc}, 64'h0);
        push_acc(1'b0, 16'h0000, 32'h0);
        start = 1'b1;
        step();
        chk("rmem_restart", {61'h0, dbg_state}, {61'h0, ST_FETCH});
        step();
        chk("rmem_restart_pc", {56'h0, pc}, 64'h1);
        do_reset();

        chk("final_acc_q", 64'(exp_q.size()), 64'h0);
        chk("final_ldr_q", 64'(ldr_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
